// File: rtl/ofs_fim_cfg_pkg.sv
// ofs_fim_cfg_pkg: FIM-wide MMIO bus widths shared by CSR masters and targets.
package ofs_fim_cfg_pkg;
    localparam int MMIO_ADDR_WIDTH = 20;
    localparam int MMIO_DATA_WIDTH = 64;
endpackage

// File: rtl/vuart_csr_init_pkg.sv
// vuart_csr_init_pkg: state encoding, response codes and command record for the CSR initiator.
package vuart_csr_init_pkg;
    localparam int CMD_ADDR_W = ofs_fim_cfg_pkg::MMIO_ADDR_WIDTH;
    localparam int CMD_DATA_W = ofs_fim_cfg_pkg::MMIO_DATA_WIDTH;
    localparam int CMD_STRB_W = CMD_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        RESP   = 3'd5
    } csr_state_e;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [CMD_STRB_W-1:0] wstrb;
    } csr_cmd_t;

    // True in the states where a bus transaction is outstanding and the watchdog runs.
    function automatic logic is_active(csr_state_e s);
        return (s == WR_REQ) || (s == WR_RSP) || (s == RD_REQ) || (s == RD_RSP);
    endfunction
endpackage

// File: rtl/ofs_fim_axi_lite_if.sv
// ofs_fim_axi_lite_if: AXI4-lite bundle with master/slave views.
interface ofs_fim_axi_lite_if #(
    parameter int AWADDR_WIDTH = 20,
    parameter int WDATA_WIDTH  = 64,
    parameter int ARADDR_WIDTH = 20,
    parameter int RDATA_WIDTH  = 64
);
    logic                       awvalid;
    logic                       awready;
    logic [AWADDR_WIDTH-1:0]    awaddr;
    logic [2:0]                 awprot;
    logic                       wvalid;
    logic                       wready;
    logic [WDATA_WIDTH-1:0]     wdata;
    logic [WDATA_WIDTH/8-1:0]   wstrb;
    logic                       bvalid;
    logic                       bready;
    logic [1:0]                 bresp;
    logic                       arvalid;
    logic                       arready;
    logic [ARADDR_WIDTH-1:0]    araddr;
    logic [2:0]                 arprot;
    logic                       rvalid;
    logic                       rready;
    logic [RDATA_WIDTH-1:0]     rdata;
    logic [1:0]                 rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vuart_csr_initiator_watchdog.sv
// csr_txn_watchdog: per-transaction cycle counter that flags expiry after TIMEOUT_CYCLES active cycles.
//   clk_i/rst_ni : clock, async active-low reset
//   start_i      : command accepted, restart count
//   clear_i      : transaction finished, zero count
//   run_i        : transaction outstanding, count this cycle
//   expire_o     : count has reached TIMEOUT_CYCLES-1 while running
module csr_txn_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = (start_i || clear_i) ? '0 : (run_i && !expire_o) ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vuart_csr_initiator.sv
// vuart_csr_initiator: single-outstanding command/response stream to AXI-lite CSR master with watchdog.
//   clk_csr, rst_n_csr        : CSR clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata/wstrb : command channel (one in flight)
//   rsp_valid/is_read/rdata/resp/timeout  : one-cycle response pulse, no backpressure
//   stray_cnt                 : saturating count of discarded late B/R beats
//   csr_lite_if               : AXI-lite master port
module vuart_csr_initiator
    import vuart_csr_init_pkg::*;
#(
    parameter int ADDR_WIDTH     = ofs_fim_cfg_pkg::MMIO_ADDR_WIDTH,
    parameter int DATA_WIDTH     = ofs_fim_cfg_pkg::MMIO_DATA_WIDTH,
    parameter int WSTRB_WIDTH    = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_csr,
    input  logic                   rst_n_csr,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_wdata,
    input  logic [WSTRB_WIDTH-1:0] cmd_wstrb,
    output logic                   rsp_valid,
    output logic                   rsp_is_read,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic [1:0]             rsp_resp,
    output logic                   rsp_timeout,
    output logic [7:0]             stray_cnt,
    ofs_fim_axi_lite_if.master     csr_lite_if
);
    csr_state_e            state_q, state_d;
    csr_cmd_t              cmd_q, cmd_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_is_read_q, rsp_is_read_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [7:0]            stray_q, stray_d;
    logic [8:0]            stray_sum;
    logic                  accept, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                  b_stray, r_stray, expire, force_to;

    assign accept  = cmd_valid && cmd_ready_q;
    assign aw_hs   = awvalid_q && csr_lite_if.awready;
    assign w_hs    = wvalid_q && csr_lite_if.wready;
    assign ar_hs   = arvalid_q && csr_lite_if.arready;
    assign b_hs    = bready_q && csr_lite_if.bvalid;
    assign r_hs    = rready_q && csr_lite_if.rvalid;
    // IDLE keeps both response readies high so late beats are drained and counted.
    assign b_stray = (state_q == IDLE) && b_hs;
    assign r_stray = (state_q == IDLE) && r_hs;

    csr_txn_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (clk_csr),
        .rst_ni   (rst_n_csr),
        .start_i  (accept),
        .clear_i  (state_q == RESP),
        .run_i    (is_active(state_q)),
        .expire_o (expire)
    );

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        rsp_is_read_d = rsp_is_read_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        force_to      = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                cmd_d.write = cmd_write;
                cmd_d.addr  = CMD_ADDR_W'(cmd_addr);
                cmd_d.wdata = CMD_DATA_W'(cmd_wdata);
                cmd_d.wstrb = CMD_STRB_W'(cmd_wstrb);
                state_d     = cmd_write ? WR_REQ : RD_REQ;
                awvalid_d   = cmd_write;
                wvalid_d    = cmd_write;
                arvalid_d   = !cmd_write;
            end
            WR_REQ: begin
                // AW and W retire independently; leave once both have gone.
                awvalid_d = awvalid_q && !aw_hs;
                wvalid_d  = wvalid_q && !w_hs;
                if (!awvalid_d && !wvalid_d) state_d = WR_RSP;
                else                         force_to = expire;
            end
            WR_RSP: if (b_hs) begin
                state_d       = RESP;
                rsp_is_read_d = 1'b0;
                rsp_rdata_d   = '0;
                rsp_resp_d    = csr_lite_if.bresp;
                rsp_timeout_d = 1'b0;
            end else force_to = expire;
            RD_REQ: if (ar_hs) begin
                arvalid_d = 1'b0;
                state_d   = RD_RSP;
            end else force_to = expire;
            RD_RSP: if (r_hs) begin
                state_d       = RESP;
                rsp_is_read_d = 1'b1;
                rsp_rdata_d   = csr_lite_if.rdata;
                rsp_resp_d    = csr_lite_if.rresp;
                rsp_timeout_d = 1'b0;
            end else force_to = expire;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Watchdog only fires when no handshake retired the current phase this cycle.
        if (force_to) begin
            state_d       = RESP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            rsp_is_read_d = !cmd_q.write;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RESP_SLVERR;
            rsp_timeout_d = 1'b1;
        end
        cmd_ready_d = (state_d == IDLE);
        bready_d    = (state_d == IDLE) || (state_d == WR_RSP);
        rready_d    = (state_d == IDLE) || (state_d == RD_RSP);
        rsp_valid_d = (state_d == RESP);
        stray_sum   = {1'b0, stray_q} + {8'd0, b_stray} + {8'd0, r_stray};
        stray_d     = stray_sum[8] ? 8'hFF : stray_sum[7:0];
    end

    always_ff @(posedge clk_csr or negedge rst_n_csr) begin
        if (!rst_n_csr) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_is_read_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
            stray_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_is_read_q <= rsp_is_read_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            stray_q       <= stray_d;
        end
    end

    assign cmd_ready           = cmd_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_is_read         = rsp_is_read_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign rsp_resp            = rsp_resp_q;
    assign rsp_timeout         = rsp_timeout_q;
    assign stray_cnt           = stray_q;
    assign csr_lite_if.awvalid = awvalid_q;
    assign csr_lite_if.awaddr  = ADDR_WIDTH'(cmd_q.addr);
    assign csr_lite_if.awprot  = 3'b000;
    assign csr_lite_if.wvalid  = wvalid_q;
    assign csr_lite_if.wdata   = DATA_WIDTH'(cmd_q.wdata);
    assign csr_lite_if.wstrb   = WSTRB_WIDTH'(cmd_q.wstrb);
    assign csr_lite_if.bready  = bready_q;
    assign csr_lite_if.arvalid = arvalid_q;
    assign csr_lite_if.araddr  = ADDR_WIDTH'(cmd_q.addr);
    assign csr_lite_if.arprot  = 3'b000;
    assign csr_lite_if.rready  = rready_q;
endmodule

// File: tb/tb_vuart_csr_initiator.sv
// tb_vuart_csr_initiator: table-driven and scoreboard-checked bench for the CSR initiator.
module tb_vuart_csr_initiator;
    localparam int AW = 20;
    localparam int DW = 64;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          cmd_ready, rsp_valid, rsp_is_read, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [7:0]    stray_cnt;

    always #5 clk = ~clk;

    ofs_fim_axi_lite_if #(.AWADDR_WIDTH(AW), .WDATA_WIDTH(DW), .ARADDR_WIDTH(AW), .RDATA_WIDTH(DW)) axi ();

    vuart_csr_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WSTRB_WIDTH(SW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_csr(clk), .rst_n_csr(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_is_read(rsp_is_read), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .stray_cnt(stray_cnt),
        .csr_lite_if(axi)
    );

    // Slave model: per-channel ready delays, B/R issued one cycle after the address/data phase.
    int            aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic          hold_b = 1'b0, inj_b = 1'b0, inj_r = 1'b0;
    logic [1:0]    s_bresp = 2'b00, s_rresp = 2'b00;
    logic [DW-1:0] s_rdata = '0;
    int            aw_cnt, w_cnt, ar_cnt;
    logic          aw_seen, w_seen, b_pend, r_pend;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [DW-1:0] cap_wdata;
    logic [SW-1:0] cap_wstrb;

    assign axi.awready = axi.awvalid && (aw_cnt >= aw_dly);
    assign axi.wready  = axi.wvalid && (w_cnt >= w_dly);
    assign axi.arready = axi.arvalid && (ar_cnt >= ar_dly);
    assign axi.bvalid  = b_pend | inj_b;
    assign axi.bresp   = s_bresp;
    assign axi.rvalid  = r_pend | inj_r;
    assign axi.rdata   = s_rdata;
    assign axi.rresp   = s_rresp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            cap_awaddr <= '0; cap_araddr <= '0; cap_wdata <= '0; cap_wstrb <= '0;
        end else begin
            aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
            ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
            if (axi.awvalid && axi.awready) begin aw_seen <= 1'b1; cap_awaddr <= axi.awaddr; end
            if (axi.wvalid && axi.wready) begin w_seen <= 1'b1; cap_wdata <= axi.wdata; cap_wstrb <= axi.wstrb; end
            if (b_pend && axi.bready) b_pend <= 1'b0;
            if ((aw_seen || (axi.awvalid && axi.awready)) && (w_seen || (axi.wvalid && axi.wready)) && !hold_b && !b_pend) begin
                b_pend <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
            end
            if (r_pend && axi.rready) r_pend <= 1'b0;
            if (axi.arvalid && axi.arready) begin r_pend <= 1'b1; cap_araddr <= axi.araddr; end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          is_read;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic          tmo;
        int            lat;
        int            acc_cyc;
    } exp_t;
    exp_t sb[$];

    // Scoreboard: every response must match the oldest expectation, including its latency.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: rsp_valid with no command outstanding at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_is_read", 64'(rsp_is_read), 64'(e.is_read));
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
                chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end
    end

    task automatic send(logic wr, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s, exp_t e_in, logic push);
        exp_t e;
        int   n;
        e = e_in;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 32) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept: cmd_ready stayed %0b for 32 cycles, required 1", cmd_ready);
        end else begin
            e.acc_cyc = cyc;
            if (push) sb.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits for rsp_valid while confirming cmd_ready stays low through RESP and rises after it.
    task automatic wait_rsp();
        logic ok, busy_bad;
        ok = 1'b0; busy_bad = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (cmd_ready) busy_bad = 1'b1;
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL rsp_wait: rsp_valid=0 after 64 cycles, required 1");
        end
        chk("cmd_ready_busy", 64'(busy_bad), 64'd0);
        @(negedge clk);
        chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
    endtask

    function automatic exp_t mk(logic rd, logic [DW-1:0] d, logic [1:0] r, logic t, int lat);
        exp_t e;
        e.is_read = rd; e.rdata = d; e.resp = r; e.tmo = t; e.lat = lat; e.acc_cyc = 0;
        return e;
    endfunction

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            aw_d, w_d, ar_d;
        logic [1:0]    sresp;
        logic [DW-1:0] srdata;
        logic [1:0]    exp_resp;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;
    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

    initial begin
        vt[0] = '{1'b1, 20'h00208, 64'h0000_0000_0000_0041, 8'hFF, 0, 0, 0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'h0, 3};
        vt[1] = '{1'b0, 20'h00000, 64'h0, 8'h00, 0, 0, 0, 2'b00, 64'h3000_0000_1000_0012, 2'b00, 64'h3000_0000_1000_0012, 3};
        vt[2] = '{1'b1, 20'h00010, 64'h1122_3344_5566_7788, 8'h0F, 0, 5, 0, 2'b00, 64'h0, 2'b00, 64'h0, 8};
        vt[3] = '{1'b1, 20'h000F0, 64'h0000_0000_0000_CAFE, 8'h03, 3, 0, 0, 2'b10, 64'h0, 2'b10, 64'h0, 6};
        vt[4] = '{1'b0, 20'h00008, 64'h0, 8'h00, 0, 0, 2, 2'b01, 64'hDEAD_BEEF_0123_4567, 2'b01, 64'hDEAD_BEEF_0123_4567, 5};
        vt[5] = '{1'b0, 20'h00FF8, 64'h0, 8'h00, 0, 0, 0, 2'b00, 64'h0000_0000_0000_55AA, 2'b00, 64'h0000_0000_0000_55AA, 3};

        repeat (3) @(negedge clk);
        chk("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 64'd0);
        chk("rst_readies", 64'({axi.bready, axi.rready, cmd_ready}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, stray_cnt}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_readies", 64'({cmd_ready, axi.bready, axi.rready}), 64'd7);

        for (int i = 0; i < 6; i++) begin
            aw_dly = vt[i].aw_d; w_dly = vt[i].w_d; ar_dly = vt[i].ar_d;
            s_bresp = vt[i].sresp; s_rresp = vt[i].sresp; s_rdata = vt[i].srdata;
            send(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].wstrb,
                 mk(!vt[i].wr, vt[i].exp_rdata, vt[i].exp_resp, 1'b0, vt[i].exp_lat), 1'b1);
            chk("prot", 64'({axi.awprot, axi.arprot}), 64'd0);
            if (vt[i].w_d > 0) begin
                @(negedge clk);
                chk("aw_dropped", 64'(axi.awvalid), 64'd0);
                chk("w_held", 64'(axi.wvalid), 64'd1);
            end
            wait_rsp();
            if (vt[i].wr) begin
                chk("awaddr", 64'(cap_awaddr), 64'(vt[i].addr));
                chk("wdata", cap_wdata, vt[i].wdata);
                chk("wstrb", 64'(cap_wstrb), 64'(vt[i].wstrb));
            end else chk("araddr", 64'(cap_araddr), 64'(vt[i].addr));
        end

        // Watchdog: AR never accepted; forced SLVERR 17 cycles after acceptance.
        aw_dly = 0; w_dly = 0; ar_dly = 1000; s_rdata = 64'h1234_5678_9ABC_DEF0; s_rresp = 2'b00;
        send(1'b0, 20'h00100, 64'h0, 8'h00, mk(1'b1, 64'h0, 2'b10, 1'b1, 17), 1'b1);
        wait_rsp();
        chk("to_arvalid", 64'(axi.arvalid), 64'd0);
        ar_dly = 0;
        repeat (10) @(negedge clk);
        inj_r = 1'b1;
        @(negedge clk);
        inj_r = 1'b0;
        chk("stray_late_r", 64'(stray_cnt), 64'd1);
        repeat (3) @(negedge clk);
        chk("sb_empty_after_stray", 64'(sb.size()), 64'd0);

        // Reset while waiting on B abandons the write without a response.
        hold_b = 1'b1;
        send(1'b1, 20'h00040, 64'hA5A5, 8'hFF, mk(1'b0, 64'h0, 2'b00, 1'b0, 3), 1'b0);
        @(negedge clk);
        chk("in_wr_rsp", 64'({axi.awvalid, axi.wvalid, axi.bready, cmd_ready}), 64'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'd0);
        chk("arst_rsp_stray", 64'({rsp_valid, stray_cnt, cmd_ready}), 64'd0);
        hold_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);
        s_rdata = 64'h0BAD_F00D_0000_0007; s_rresp = 2'b00;
        send(1'b0, 20'h00018, 64'h0, 8'h00, mk(1'b1, 64'h0BAD_F00D_0000_0007, 2'b00, 1'b0, 3), 1'b1);
        wait_rsp();

        // Stray B beats in IDLE saturate the counter.
        for (int p = 0; p < 300; p++) begin
            @(negedge clk); inj_b = 1'b1;
            @(negedge clk); inj_b = 1'b0;
            if (p == 253) chk("stray_254", 64'(stray_cnt), 64'd254);
        end
        chk("stray_sat", 64'(stray_cnt), 64'd255);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
